// File: rtl/reservation_entry_allocator_pkg.sv
// Shared scheduling defines for the reservation-station entry allocator:
// entry count, index/count widths and the per-slot grant record.
package reservation_entry_allocator_pkg;

  localparam int RS_ENTRIES = 16;
  localparam int RS_IDX_W   = 4;
  localparam int RS_CNT_W   = 5;   // must hold 0..RS_ENTRIES without wrapping
  localparam int NUM_SLOTS  = 2;   // dispatch slots per cycle

  typedef logic [RS_ENTRIES-1:0] rs_map_t;
  typedef logic [RS_IDX_W-1:0]   rs_idx_t;
  typedef logic [RS_CNT_W-1:0]   rs_cnt_t;

  // One dispatch-slot grant: valid flag plus the granted entry index.
  typedef struct packed {
    logic    valid;
    rs_idx_t entry;
  } alloc_rsp_t;

endpackage

// File: rtl/reservation_entry_allocator_if.sv
// Dispatch / release / status bundle between the dispatch stage and the
// reservation-entry allocator. The allocator is the slave side.
interface reservation_entry_allocator_if;
  import reservation_entry_allocator_pkg::*;

  logic    iFLUSH;
  logic    iDISP0_VALID;
  logic    iDISP1_VALID;
  logic    oDISP_LOCK;
  logic    oALLOC0_VALID;
  rs_idx_t oALLOC0_ENTRY;
  logic    oALLOC1_VALID;
  rs_idx_t oALLOC1_ENTRY;
  logic    iFREE_VALID;
  rs_map_t iFREE_MASK;
  rs_cnt_t oFREE_COUNT;
  logic    oFULL;
  logic    oEMPTY;

  modport master (
    output iFLUSH, iDISP0_VALID, iDISP1_VALID, iFREE_VALID, iFREE_MASK,
    input  oDISP_LOCK, oALLOC0_VALID, oALLOC0_ENTRY, oALLOC1_VALID,
           oALLOC1_ENTRY, oFREE_COUNT, oFULL, oEMPTY
  );

  modport slave (
    input  iFLUSH, iDISP0_VALID, iDISP1_VALID, iFREE_VALID, iFREE_MASK,
    output oDISP_LOCK, oALLOC0_VALID, oALLOC0_ENTRY, oALLOC1_VALID,
           oALLOC1_ENTRY, oFREE_COUNT, oFULL, oEMPTY
  );

endinterface

// File: rtl/reservation_free_entry_select.sv
// Purely combinational finder for the lowest and second-lowest zero bit of
// the busy bitmap, i.e. the two lowest-numbered free entries.
module reservation_free_entry_select
  import reservation_entry_allocator_pkg::*;
(
  input  rs_map_t busy,
  output logic    first_vld,
  output rs_idx_t first_idx,
  output logic    second_vld,
  output rs_idx_t second_idx
);

  // Priority scan from entry 0 upward; first hit fills slot 0, next fills slot 1.
  always_comb begin
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!busy[i]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = RS_IDX_W'(i);
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = RS_IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/reservation_entry_allocator.sv
// Reservation-station entry allocator: tracks a busy bitmap, grants up to two
// entries per cycle combinationally, applies releases/flush at the next edge
// and publishes registered free-count / full / empty / dispatch-lock status.
module reservation_entry_allocator
  import reservation_entry_allocator_pkg::*;
#(
  parameter int LOCK_TH = 2   // lock dispatch when free entries < LOCK_TH (1..2)
) (
  input  logic                          iCLOCK,
  input  logic                          inRESET,
  reservation_entry_allocator_if.slave  bus
);

  rs_map_t busy_q;
  rs_map_t busy_nxt;
  rs_map_t alloc_mask;
  rs_map_t free_mask;
  rs_cnt_t cnt_q;
  rs_cnt_t cnt_nxt;
  logic    full_q;
  logic    empty_q;
  logic    lock_q;

  logic    first_vld;
  logic    second_vld;
  rs_idx_t first_idx;
  rs_idx_t second_idx;

  alloc_rsp_t [NUM_SLOTS-1:0] grant;

  // Free entries counted as zeros of the bitmap; width covers the all-free case.
  function automatic rs_cnt_t count_free(input rs_map_t m);
    rs_cnt_t c;
    c = '0;
    for (int i = 0; i < RS_ENTRIES; i++)
      c = c + {{(RS_CNT_W-1){1'b0}}, ~m[i]};
    return c;
  endfunction

  reservation_free_entry_select u_sel (
    .busy       (busy_q),
    .first_vld  (first_vld),
    .first_idx  (first_idx),
    .second_vld (second_vld),
    .second_idx (second_idx)
  );

  // Same-cycle grants off the registered bitmap; flush and reset suppress them.
  always_comb begin
    grant[0].valid = inRESET && !bus.iFLUSH && bus.iDISP0_VALID && !lock_q && first_vld;
    grant[0].entry = first_idx;
    grant[1].valid = grant[0].valid && bus.iDISP1_VALID && second_vld;
    grant[1].entry = second_idx;
  end

  assign bus.oALLOC0_VALID = grant[0].valid;
  assign bus.oALLOC0_ENTRY = grant[0].entry;
  assign bus.oALLOC1_VALID = grant[1].valid;
  assign bus.oALLOC1_ENTRY = grant[1].entry;

  // Next bitmap: release only busy entries (so a mask bit on a just-granted
  // entry cannot undo its grant), then add grants; flush wins over both.
  always_comb begin
    alloc_mask = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (grant[s].valid) alloc_mask[grant[s].entry] = 1'b1;
    free_mask = bus.iFREE_VALID ? bus.iFREE_MASK : '0;
    if (bus.iFLUSH) busy_nxt = '0;
    else            busy_nxt = (busy_q & ~free_mask) | alloc_mask;
    cnt_nxt = count_free(busy_nxt);
  end

  // Bitmap and status registers; status is derived from the next-state bitmap
  // so it always matches the bitmap the following cycle grants from.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      busy_q  <= '0;
      cnt_q   <= RS_CNT_W'(RS_ENTRIES);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      lock_q  <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == '0);
      empty_q <= (cnt_nxt == RS_CNT_W'(RS_ENTRIES));
      lock_q  <= (int'(cnt_nxt) < LOCK_TH);
    end
  end

  assign bus.oFREE_COUNT = cnt_q;
  assign bus.oFULL       = full_q;
  assign bus.oEMPTY      = empty_q;
  assign bus.oDISP_LOCK  = lock_q;

endmodule

// File: doc/reservation_entry_allocator.md
RESERVATION_ENTRY_ALLOCATOR -- requirements
Module: reservation_entry_allocator

Interface
REQ-001 Parameter LOCK_TH, default 2: dispatch is locked when free entries are fewer than this value (legal range 1..2).
REQ-002 iCLOCK  input  1  sole clock; all state updates on its rising edge.
REQ-003 inRESET  input  1  reset, asynchronous assert, active-low.
REQ-004 iFLUSH  input  1  pipeline flush; frees all 16 entries.
REQ-005 iDISP0_VALID  input  1  dispatch slot 0 requests one entry.
REQ-006 iDISP1_VALID  input  1  dispatch slot 1 requests one entry; legal only with iDISP0_VALID.
REQ-007 oDISP_LOCK  output  1  registered; dispatch must not present requests while high.
REQ-008 oALLOC0_VALID / oALLOC0_ENTRY  output  1 / 4  same-cycle grant and entry index for slot 0.
REQ-009 oALLOC1_VALID / oALLOC1_ENTRY  output  1 / 4  same-cycle grant and entry index for slot 1.
REQ-010 iFREE_VALID / iFREE_MASK  input  1 / 16  issue-side release; bit n set frees entry n.
REQ-011 oFREE_COUNT  output  5  registered number of free entries, 0..16.
REQ-012 oFULL / oEMPTY  output  1 / 1  registered: no entry free / all 16 free.

Function
REQ-013 State: 16-bit busy bitmap; bit n = 1 means entry n is allocated.
REQ-014 Slot 0 grant: oALLOC0_VALID = iDISP0_VALID & !oDISP_LOCK & (a free entry exists); index = lowest-numbered free entry.
REQ-015 Slot 1 grant: oALLOC1_VALID = iDISP1_VALID & oALLOC0_VALID & (a second free entry exists); index = second-lowest free entry.
REQ-016 Grant outputs are combinational from the registered bitmap (0-cycle latency); granted entries are marked busy at the next edge.
REQ-017 Release: with iFREE_VALID high, masked busy entries are cleared at the next edge (1-cycle latency); mask bits on already-free entries are ignored.
REQ-018 Allocation and release in the same cycle are both applied (disjoint by construction); a freed entry is not grantable until the following cycle.
REQ-019 iFLUSH has priority: the next state is all-free regardless of same-cycle grants or releases; grant outputs are forced low while iFLUSH is high.
REQ-020 oFREE_COUNT, oFULL, oEMPTY and oDISP_LOCK are registered from the next-state bitmap: count = popcount(~next_busy), full = (count == 0), empty = (count == 16), lock = (count < LOCK_TH).
REQ-021 The count is 5 bits wide so that 16 free entries is representable; it never wraps.
REQ-022 A slot-1 request without a slot-0 request produces no grant and leaves state unchanged.

Reset
REQ-023 While inRESET is low: bitmap = 0, oFREE_COUNT = 16, oEMPTY = 1, oFULL = 0, oDISP_LOCK = 0, grant outputs = 0.
REQ-024 Reset asserted mid-operation discards all allocations immediately; there is no pending-state carryover.

Structure
REQ-025 Entry count (16), index width (4) and count width (5) are defined in the shared scheduling defines file; the module uses no local magic numbers for them.
REQ-026 One sub-module, reservation_free_entry_select: a purely combinational block that finds the lowest and second-lowest zero bit of a 16-bit vector, with valid flags.
REQ-027 Popcount is implemented inside the allocator; no other sub-modules.

Verification
REQ-028 Reset release, iDISP0/1_VALID=1 -> ALLOC0=0, ALLOC1=1 granted; next cycle oFREE_COUNT=14.
REQ-029 Dispatch 2 per cycle for 7 cycles -> count 2; LOCK_TH=2: one further pair -> count 0, oFULL=1, oDISP_LOCK=1, subsequent requests get no grant.
REQ-030 Full, iFREE_MASK=16'h0005 -> next cycle count=2, lock=0; a pair request gets entries 0 and 2.
REQ-031 Same cycle: grant 2 while freeing 3 other entries (count 8) -> next count 9.
REQ-032 iFLUSH with a pair request and a release pending -> no grants; next cycle count=16, oEMPTY=1.
REQ-033 inRESET pulsed low asynchronously between edges with 10 entries busy -> outputs reach reset values before the next edge.
